// File: rtl/mips_multi_pkg.sv
// Shared encodings for the multicycle MIPS controller, datapath and bench.
// State, opcode, mux-select and ALU control constants plus output decode.
package mips_multi_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_4     = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       fetch;
    logic       memwrite;
    logic       regwrite;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  // Strobes that depend on mem_ready/zero are kept as
  // qualifiers here and resolved at the controller outputs.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c         = '0;
    c.alusrcb = ALUSRCB_B;
    c.pcsrc   = PCSRC_ALU;
    c.aluop   = ALUOP_ADD;
    case (s)
      FETCH: begin
        c.fetch   = 1'b1;
        c.alusrcb = ALUSRCB_4;
      end
      DECODE: c.alusrcb = ALUSRCB_IMMSH;
      MEMADR, ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
      end
      MEMRD: c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PCSRC_ALUOUT;
        c.branch  = 1'b1;
      end
      ADDIWB: c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc   = PCSRC_JUMP;
        c.pcwrite = 1'b1;
      end
      default: c.fetch = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic op_legal(
    input logic [5:0] op,
    input logic       bne_en
  );
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW,
      OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      OP_BNE:                ok = bne_en;
      default:               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_multi_aludec.sv
// ALU decoder: maps aluop and funct to the 3-bit ALU control code.
// Purely combinational; funct only matters when aluop selects it.
module mips_multi_aludec
  import mips_multi_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  logic [2:0] fn_ctrl;

  always_comb begin
    fn_ctrl = ALU_AND;
    case (funct_i)
      FUNCT_ADD: fn_ctrl = ALU_ADD;
      FUNCT_SUB: fn_ctrl = ALU_SUB;
      FUNCT_AND: fn_ctrl = ALU_AND;
      FUNCT_OR:  fn_ctrl = ALU_OR;
      FUNCT_SLT: fn_ctrl = ALU_SLT;
      default:   fn_ctrl = ALU_AND;
    endcase
  end

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      default:   alucontrol_o = fn_ctrl;
    endcase
  end

endmodule

// File: rtl/mips_multi_controller.sv
// Multicycle MIPS main control FSM with ALU decoder.
// Optional MIPS_MULTI_BNE_EN adds bne as an inverted-sense branch.
module mips_multi_controller
  import mips_multi_pkg::*;
#(
  parameter bit MEM_HS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op
);

`ifdef MIPS_MULTI_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   bne_q, bne_d;
  logic   rdy;
  logic   br_take;

  assign rdy = MEM_HS ? mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    bne_d   = bne_q;
    case (state_q)
      FETCH: if (rdy) state_d = DECODE;
      DECODE: begin
        bne_d = 1'b0;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
`ifdef MIPS_MULTI_BNE_EN
          OP_BNE: begin
            state_d = BRANCH;
            bne_d   = 1'b1;
          end
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD: if (rdy) state_d = MEMWB;
      MEMWR: if (rdy) state_d = FETCH;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH,
      ADDIWB, JUMP: state_d = FETCH;
      default: state_d = FETCH;
    endcase
    ctrl_d = ctrl_of(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_of(FETCH);
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      bne_q   <= bne_d;
    end
  end

  // Strobes are gated by reset so nothing fires while it is held low.
  assign br_take = ctrl_q.branch & (zero ^ bne_q);

  assign pcen = reset & ((ctrl_q.fetch & rdy)
              | ctrl_q.pcwrite | br_take);
  assign irwrite  = reset & ctrl_q.fetch & rdy;
  assign memwrite = reset & ctrl_q.memwrite;
  assign regwrite = reset & ctrl_q.regwrite;

  assign illegal_op = reset
                    & (state_q == DECODE)
                    & ~op_legal(op, BNE_EN);

  assign iord     = ctrl_q.iord;
  assign memtoreg = ctrl_q.memtoreg;
  assign regdst   = ctrl_q.regdst;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;

  mips_multi_aludec u_aludec (
    .aluop_i      (ctrl_q.aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

endmodule

// File: tb/tb_mips_multi_controller.sv
// Bench for mips_multi_controller: per-instruction phase scripts
// with random handshake waits, checked against an output table.
module tb_mips_multi_controller;

`ifdef MIPS_MULTI_BNE_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif

  typedef enum int {
    P_F, P_D, P_MA, P_MR, P_WB, P_MW,
    P_EX, P_AW, P_BR, P_AI, P_AIW, P_JP
  } ph_t;

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } obs_t;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, irwrite, memwrite, regwrite;
  logic       iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;

  int n_cmp;
  int n_err;

  obs_t act_q[$];
  obs_t exp_q[$];
  ph_t  ph_q[$];

  mips_multi_controller #(.MEM_HS(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [5:0] o);
    if (o == 6'b100011 || o == 6'b101011) return 1'b1;
    if (o == 6'b000000 || o == 6'b000100) return 1'b1;
    if (o == 6'b001000 || o == 6'b000010) return 1'b1;
    if (o == 6'b000101) return BNE;
    return 1'b0;
  endfunction

  function automatic logic [2:0] fcode(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  // Expected outputs of one named phase of an instruction.
  function automatic obs_t model(
    input ph_t ph, input logic r, input logic z,
    input logic [5:0] o, input logic [5:0] f
  );
    obs_t e;
    e = '0;
    e.alucontrol = 3'b010;
    case (ph)
      P_F: begin
        e.alusrcb = 2'b01;
        e.irwrite = r;
        e.pcen    = r;
      end
      P_D: begin
        e.alusrcb = 2'b11;
        e.illegal = !legal(o);
      end
      P_MA, P_AI: begin
        e.alusrca = 1'b1;
        e.alusrcb = 2'b10;
      end
      P_MR: e.iord = 1'b1;
      P_WB: begin
        e.memtoreg = 1'b1;
        e.regwrite = 1'b1;
      end
      P_MW: begin
        e.iord     = 1'b1;
        e.memwrite = 1'b1;
      end
      P_EX: begin
        e.alusrca    = 1'b1;
        e.alucontrol = fcode(f);
      end
      P_AW: begin
        e.regdst   = 1'b1;
        e.regwrite = 1'b1;
      end
      P_BR: begin
        e.alusrca    = 1'b1;
        e.alucontrol = 3'b110;
        e.pcsrc      = 2'b01;
        e.pcen       = (o == 6'b000101) ? !z : z;
      end
      P_AIW: e.regwrite = 1'b1;
      P_JP: begin
        e.pcsrc = 2'b10;
        e.pcen  = 1'b1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic obs_t sample();
    return {pcen, irwrite, memwrite, regwrite,
            iord, memtoreg, regdst, alusrca,
            alusrcb, pcsrc, alucontrol, illegal_op};
  endfunction

  // One clock of a phase: drive at posedge+1, record at negedge.
  task automatic cyc(input ph_t ph, input logic r, input logic z);
    mem_ready = r;
    zero      = z;
    @(negedge clk);
    ph_q.push_back(ph);
    exp_q.push_back(model(ph, r, z, op, funct));
    act_q.push_back(sample());
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(
    input logic [5:0] o, input logic [5:0] f,
    input logic zb, input int wf, input int wm
  );
    op    = o;
    funct = f;
    repeat (wf) cyc(P_F, 1'b0, rb());
    cyc(P_F, 1'b1, rb());
    cyc(P_D, rb(), rb());
    if (o == 6'b100011) begin
      cyc(P_MA, rb(), rb());
      repeat (wm) cyc(P_MR, 1'b0, rb());
      cyc(P_MR, 1'b1, rb());
      cyc(P_WB, rb(), rb());
    end else if (o == 6'b101011) begin
      cyc(P_MA, rb(), rb());
      repeat (wm) cyc(P_MW, 1'b0, rb());
      cyc(P_MW, 1'b1, rb());
    end else if (o == 6'b000000) begin
      cyc(P_EX, rb(), rb());
      cyc(P_AW, rb(), rb());
    end else if (o == 6'b000100 || (BNE && o == 6'b000101)) begin
      cyc(P_BR, rb(), zb);
    end else if (o == 6'b001000) begin
      cyc(P_AI, rb(), rb());
      cyc(P_AIW, rb(), rb());
    end else if (o == 6'b000010) begin
      cyc(P_JP, rb(), rb());
    end
  endtask

  task automatic clear_q();
    act_q.delete();
    exp_q.delete();
    ph_q.delete();
  endtask

  task automatic test_reset();
    obs_t e, a;
    reset     = 1'b0;
    op        = 6'b100011;
    funct     = 6'b100000;
    mem_ready = 1'b1;
    zero      = 1'b1;
    e = model(P_F, 1'b0, 1'b0, op, funct);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = sample();
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d actual=%h required=%h",
                 i, a, e);
      end
      @(posedge clk);
      #1;
    end
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    a = sample();
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL reset_release actual=%h required=%h", a, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lw();
    clear_q();
    run_instr(6'b100011, 6'($urandom), rb(), 0, 0);
    run_instr(6'b100011, 6'($urandom), rb(), 2, 3);
    foreach (act_q[i]) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL lw cyc%0d ph=%s actual=%h required=%h",
                 i, ph_q[i].name(), act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_sw_wait();
    int mw;
    clear_q();
    run_instr(6'b101011, 6'($urandom), rb(), 0, 2);
    run_instr(6'b101011, 6'($urandom), rb(), 1, 0);
    foreach (act_q[i]) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL sw cyc%0d ph=%s actual=%h required=%h",
                 i, ph_q[i].name(), act_q[i], exp_q[i]);
      end
    end
    mw = 0;
    foreach (act_q[i]) mw += int'(act_q[i].memwrite);
    n_cmp++;
    if (mw !== 4) begin
      n_err++;
      $display("FAIL sw_memwrite_cycles actual=%0d required=4", mw);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fl[6];
    fl = '{6'b100000, 6'b100010, 6'b100100,
           6'b100101, 6'b101010, 6'b111111};
    clear_q();
    foreach (fl[k]) run_instr(6'b000000, fl[k], rb(), 0, 0);
    repeat (4) run_instr(6'b000000, 6'($urandom), rb(), 0, 0);
    foreach (act_q[i]) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rtype cyc%0d ph=%s actual=%h required=%h",
                 i, ph_q[i].name(), act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_branch();
    clear_q();
    run_instr(6'b000100, 6'($urandom), 1'b1, 0, 0);
    run_instr(6'b000100, 6'($urandom), 1'b0, 0, 0);
    run_instr(6'b000101, 6'($urandom), 1'b1, 0, 0);
    run_instr(6'b000101, 6'($urandom), 1'b0, 0, 0);
    foreach (act_q[i]) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL branch cyc%0d ph=%s actual=%h required=%h",
                 i, ph_q[i].name(), act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_addi_jump();
    clear_q();
    run_instr(6'b001000, 6'($urandom), rb(), 1, 0);
    run_instr(6'b000010, 6'($urandom), rb(), 0, 0);
    run_instr(6'b000010, 6'($urandom), rb(), 2, 0);
    foreach (act_q[i]) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL addi_j cyc%0d ph=%s actual=%h required=%h",
                 i, ph_q[i].name(), act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] o;
    clear_q();
    run_instr(6'b111111, 6'($urandom), rb(), 0, 0);
    for (int k = 0; k < 6; k++) begin
      o = 6'($urandom);
      run_instr(o, 6'($urandom), rb(), 0, 1);
    end
    foreach (act_q[i]) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL illegal cyc%0d ph=%s actual=%h required=%h",
                 i, ph_q[i].name(), act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    op    = 6'b100011;
    funct = 6'($urandom);
    cyc(P_F, 1'b1, rb());
    cyc(P_D, rb(), rb());
    cyc(P_MA, rb(), rb());
    mem_ready = 1'b0;
    @(negedge clk);
    ph_q.push_back(P_MR);
    exp_q.push_back(model(P_MR, 1'b0, zero, op, funct));
    act_q.push_back(sample());
    #2;
    reset     = 1'b0;
    mem_ready = 1'b1;
    #1;
    ph_q.push_back(P_F);
    exp_q.push_back(model(P_F, 1'b0, zero, op, funct));
    act_q.push_back(sample());
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(P_F, 1'b0, rb());
    foreach (act_q[i]) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL reset_mid cyc%0d ph=%s actual=%h required=%h",
                 i, ph_q[i].name(), act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[8];
    logic [5:0] o;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
            6'b000101, 6'b001000, 6'b000010, 6'b000000};
    clear_q();
    for (int k = 0; k < 40; k++) begin
      o = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                      : ops[$urandom_range(0, 7)];
      run_instr(o, 6'($urandom), rb(),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end
    foreach (act_q[i]) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL random cyc%0d ph=%s actual=%h required=%h",
                 i, ph_q[i].name(), act_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b0;
    op        = '0;
    funct     = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_branch();
    test_addi_jump();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
